timer_int_ctrl: RTL
===================

// Module: timer_int_ctrl
// PURPOSE
// - Consumes the overflow and underflow trigger pulses from the timer compare stage.
// - Latches them into sticky, software-visible status bits and counts them.
// - Drives trig_clr back to the compare stage when software clears a status bit.
// - Produces masked interrupt lines toward the interrupt handler.
// - All registers are accessed over a zero-wait-state APB slave port.
// PARAMETERS
// - CNT_W   8   width of each saturating event counter (field within EVCNT)
// - ADDR_W  4   APB byte-address width decoded by this block
// PORTS
// - pclk          in   1       system clock, all logic on rising edge
// - preset        in   1       synchronous reset, active-high
// - ovf_trig      in   1       overflow trigger, sampled every cycle (level; high = event)
// - udf_trig      in   1       underflow trigger, sampled every cycle (level; high = event)
// - psel          in   1       APB select
// - penable       in   1       APB enable (access phase)
// - pwrite        in   1       APB direction, 1 = write
// - paddr         in   ADDR_W  APB byte address
// - pwdata        in   32      APB write data
// - prdata        out  32      APB read data
// - pready        out  1       constant 1
// - pslverr       out  1       error on unmapped address
// - trig_clr      out  2       [0] clears ovf trigger, [1] clears udf trigger; 1-cycle pulses
// - int_ovf       out  1       registered ovf_st & ovf_en
// - int_udf       out  1       registered udf_st & udf_en
// - tim_int       out  1       registered int_ovf | int_udf
// BEHAVIOUR
// - Register map:
//   - 0x0 IER: [0] ovf_en, [1] udf_en; R/W; other bits read 0.
//   - 0x4 ISR: [0] ovf_st, [1] udf_st; R/W1C.
//   - 0x8 EVCNT: [CNT_W-1:0] ovf_cnt, [2*CNT_W-1:CNT_W] udf_cnt; R; any write clears both counters.
// - APB access: a write commits in the cycle with psel & penable & pwrite.
// - prdata is combinational from the current register values during psel & penable & !pwrite; 0 otherwise.
// - pslverr: asserted with psel & penable when paddr is not 0x0/0x4/0x8, or when paddr[1:0] != 0.
//   An erroring write has no effect.
// - Reset (preset=1 at a pclk edge): IER, ISR, counters, trig_clr, int_ovf, int_udf, tim_int all 0.
// - Reset wins over any same-cycle trigger or write.
// - Status set: ovf_trig=1 in cycle N -> ovf_st=1 at edge N+1. Same rule for udf.
// - Counter: ovf_trig=1 in cycle N -> ovf_cnt+1 at edge N+1. Saturates at 2^CNT_W-1, no wrap. Same for udf.
// - Every cycle with a trigger high counts as one event.
// - Set beats clear: a trigger and a W1C to the same bit in the same cycle leave the bit 1.
// - Increment beats clear: a trigger and an EVCNT write in the same cycle leave the counter at 1.
// - W1C: a write to ISR with pwdata[i]=1 clears status[i] at the next edge.
//   - trig_clr[i]=1 for exactly that following cycle; otherwise 0.
//   - Writing 0 leaves the bit unchanged.
// - trig_clr[i] pulses even when status[i] was already 0.
// - Interrupts: int_x <= x_st & x_en each edge, so int_x rises 1 cycle after the status bit.
//   tim_int <= (ovf_st&ovf_en)|(udf_st&udf_en), aligned with int_ovf/int_udf.
// - Changing IER never alters ISR. A masked event stays pending and raises int_x once enabled.
// TESTING
// - Reset then read 0x0/0x4/0x8 -> all 0; trig_clr=0, tim_int=0.
// - IER=3; ovf_trig 1 cycle at N -> ovf_st=1 at N+1, int_ovf=tim_int=1 at N+2, ovf_cnt=1.
// - Write ISR=0x1 -> ovf_st=0 next edge, trig_clr=2'b01 for 1 cycle, tim_int low one cycle later.
// - udf_trig and ISR W1C bit1 in the same cycle -> udf_st stays 1, trig_clr[1] still pulses.
// - Hold ovf_trig high 300 cycles -> ovf_cnt=255 (saturated); EVCNT write -> 0.
// - Read paddr=0xC -> pslverr=1, prdata=0; preset mid-burst -> all outputs 0 next edge.

Source files
------------

// File: rtl/timer_int_ctrl_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// timer_int_ctrl_if : APB slave bus bundle for the timer interrupt controller
// Revision: 1.0
// ---------------------------------------------------------------------------
interface timer_int_ctrl_if #(
    parameter int ADDR_W = 4
) ();
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [31:0]       pwdata;
    logic [31:0]       prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface
`default_nettype wire

// File: rtl/timer_int_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// timer_int_ctrl : sticky ovf/udf status, saturating event counters, masked IRQs
// Revision: 1.0
// ---------------------------------------------------------------------------
module timer_int_ctrl #(
    parameter int CNT_W  = 8,
    parameter int ADDR_W = 4
) (
    input  wire logic        pclk,
    input  wire logic        preset,
    input  wire logic        ovf_trig,
    input  wire logic        udf_trig,
    timer_int_ctrl_if.slave  apb,
    output logic [1:0]       trig_clr,
    output logic             int_ovf,
    output logic             int_udf,
    output logic             tim_int
);

    localparam logic [ADDR_W-1:0] c_ADDR_IER   = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] c_ADDR_ISR   = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] c_ADDR_EVCNT = ADDR_W'(8);
    localparam logic [CNT_W-1:0]  c_CNT_MAX    = '1;

    logic             w_access;
    logic             w_sel_ier;
    logic             w_sel_isr;
    logic             w_sel_evcnt;
    logic             w_addr_ok;
    logic             w_wr_ier;
    logic             w_wr_isr;
    logic             w_wr_evcnt;
    logic [31:0]      w_prdata;
    logic             w_unused_pwdata;

    logic [1:0]       ier_q, ier_d;
    logic [1:0]       st_q, st_d;
    logic [CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;
    logic [CNT_W-1:0] udf_cnt_q, udf_cnt_d;
    logic [1:0]       trig_clr_q, trig_clr_d;
    logic             int_ovf_q, int_ovf_d;
    logic             int_udf_q, int_udf_d;
    logic             tim_int_q, tim_int_d;

    // Aligned offsets are implied by exact equality with the three mapped addresses.
    assign w_access    = apb.psel & apb.penable;
    assign w_sel_ier   = (apb.paddr == c_ADDR_IER);
    assign w_sel_isr   = (apb.paddr == c_ADDR_ISR);
    assign w_sel_evcnt = (apb.paddr == c_ADDR_EVCNT);
    assign w_addr_ok   = w_sel_ier | w_sel_isr | w_sel_evcnt;
    assign w_wr_ier    = w_access & apb.pwrite & w_sel_ier;
    assign w_wr_isr    = w_access & apb.pwrite & w_sel_isr;
    assign w_wr_evcnt  = w_access & apb.pwrite & w_sel_evcnt;

    assign w_unused_pwdata = ^apb.pwdata[31:2];

    // Increment is applied after the clear so a same-cycle event leaves the count at 1.
    function automatic logic [CNT_W-1:0] f_next_cnt(
        input logic [CNT_W-1:0] cnt,
        input logic             inc,
        input logic             clr
    );
        logic [CNT_W-1:0] base;
        base = clr ? '0 : cnt;
        if (inc && (base != c_CNT_MAX)) begin
            base = base + 1'b1;
        end
        return base;
    endfunction

    always_comb begin
        ier_d      = w_wr_ier ? apb.pwdata[1:0] : ier_q;
        trig_clr_d = w_wr_isr ? apb.pwdata[1:0] : 2'b00;
        st_d       = (st_q & ~trig_clr_d) | {udf_trig, ovf_trig};
        ovf_cnt_d  = f_next_cnt(ovf_cnt_q, ovf_trig, w_wr_evcnt);
        udf_cnt_d  = f_next_cnt(udf_cnt_q, udf_trig, w_wr_evcnt);
        int_ovf_d  = st_q[0] & ier_q[0];
        int_udf_d  = st_q[1] & ier_q[1];
        tim_int_d  = int_ovf_d | int_udf_d;
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            ier_q      <= 2'b00;
            st_q       <= 2'b00;
            ovf_cnt_q  <= '0;
            udf_cnt_q  <= '0;
            trig_clr_q <= 2'b00;
            int_ovf_q  <= 1'b0;
            int_udf_q  <= 1'b0;
            tim_int_q  <= 1'b0;
        end else begin
            ier_q      <= ier_d;
            st_q       <= st_d;
            ovf_cnt_q  <= ovf_cnt_d;
            udf_cnt_q  <= udf_cnt_d;
            trig_clr_q <= trig_clr_d;
            int_ovf_q  <= int_ovf_d;
            int_udf_q  <= int_udf_d;
            tim_int_q  <= tim_int_d;
        end
    end

    always_comb begin
        w_prdata = '0;
        if (w_access && !apb.pwrite) begin
            if (w_sel_ier) begin
                w_prdata[1:0] = ier_q;
            end else if (w_sel_isr) begin
                w_prdata[1:0] = st_q;
            end else if (w_sel_evcnt) begin
                w_prdata[2*CNT_W-1:0] = {udf_cnt_q, ovf_cnt_q};
            end
        end
    end

    assign apb.prdata  = w_prdata;
    assign apb.pready  = 1'b1;
    assign apb.pslverr = w_access & ~w_addr_ok;

    assign trig_clr = trig_clr_q;
    assign int_ovf  = int_ovf_q;
    assign int_udf  = int_udf_q;
    assign tim_int  = tim_int_q;

endmodule
`default_nettype wire
